delay_sum_beamformer: RTL and testbench

//  Multi-channel delay-and-sum beamformer core. Each of NCH ADC channels feeds a

---
 rtl/delay_sum_beamformer.sv | 152 +++++++++++++++
 tb/tb_delay_sum_beamformer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-channel programmable sample delay lines, summed
// and emitted only at sample indices listed in a loadable focal-point table.
module delay_sum_beamformer #(
  parameter  int NCH  = 4,
  parameter  int DW   = 12,
  parameter  int IW   = 16,
  parameter  int DMAX = 32,
  parameter  int NPTS = 1024,
  localparam int TAW  = $clog2(NPTS),
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DAW  = $clog2(DMAX),
  localparam int OW   = DW + $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH*DW-1:0] sample_in,
  input  logic [IW-1:0]     sample_index,
  input  logic              sample_valid,
  input  logic              start,
  input  logic [TAW:0]      num_points,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [DAW-1:0]    cfg_delay,
  input  logic              tbl_we,
  input  logic [TAW-1:0]    tbl_addr,
  input  logic [IW-1:0]     tbl_data,
  output logic [OW-1:0]     output_value,
  output logic              data_good,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [TAW-1:0] ptr_q, ptr_d;
  logic [TAW:0]   npts_q, npts_d;
  logic           match;
  logic           cfg_ok;

  logic [DW-1:0]  dl_mem [NCH][DMAX];
  logic [DAW-1:0] dly_q  [NCH];
  logic [DAW-1:0] wr_ptr_q;
  logic [DAW-1:0] rd_addr [NCH];
  logic [DW-1:0]  tap    [NCH];

  logic [IW-1:0]  tbl_mem [NPTS];
  logic [IW-1:0]  tbl_q;

  logic [DW-1:0]  tap_s1 [NCH];
  logic           match_s1;
  logic [OW-1:0]  sum;

  // Configuration is frozen while a scan is running.
  assign cfg_ok = (state_q != S_RUN);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      npts_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      npts_q  <= npts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    npts_d  = npts_q;
    match   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ptr_d   = '0;
          npts_d  = num_points;
          state_d = (num_points == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (sample_valid && (sample_index == tbl_q)) begin
          match = 1'b1;
          ptr_d = ptr_q + TAW'(1);
          if ({1'b0, ptr_q} == (npts_q - (TAW+1)'(1))) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Table RAM is unreset; tbl_q is fetched at the next pointer so the entry
  // is ready the cycle right after a match, with write-through for same-address writes.
  always_ff @(posedge clk) begin
    if (cfg_ok && tbl_we) tbl_mem[tbl_addr] <= tbl_data;
    if (cfg_ok && tbl_we && (tbl_addr == ptr_d)) tbl_q <= tbl_data;
    else                                         tbl_q <= tbl_mem[ptr_d];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        dly_q[k] <= '0;
        for (int i = 0; i < DMAX; i++) dl_mem[k][i] <= '0;
      end
    end else begin
      if (sample_valid) begin
        for (int k = 0; k < NCH; k++) dl_mem[k][wr_ptr_q] <= sample_in[k*DW +: DW];
        wr_ptr_q <= wr_ptr_q + DAW'(1);
      end
      if (cfg_ok && cfg_we && (int'(cfg_ch) < NCH)) dly_q[cfg_ch] <= cfg_delay;
    end
  end

  // Delay 0 bypasses the memory; otherwise read the entry written dly valid-cycles ago.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      rd_addr[k] = wr_ptr_q - dly_q[k];
      tap[k]     = (dly_q[k] == '0) ? sample_in[k*DW +: DW] : dl_mem[k][rd_addr[k]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_s1 <= 1'b0;
      for (int k = 0; k < NCH; k++) tap_s1[k] <= '0;
    end else begin
      match_s1 <= match;
      for (int k = 0; k < NCH; k++) tap_s1[k] <= tap[k];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NCH; k++) sum = sum + OW'(tap_s1[k]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output_value <= '0;
      data_good    <= 1'b0;
    end else begin
      data_good <= match_s1;
      if (match_s1) output_value <= sum;
    end
  end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Scoreboard bench for delay_sum_beamformer: directed scans push hand-computed
// frames (value and arrival cycle); a monitor checks every data_good strobe.
module tb_delay_sum_beamformer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [47:0] sample_in;
  logic [15:0] sample_index;
  logic        sample_valid;
  logic        start;
  logic [10:0] num_points;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [4:0]  cfg_delay;
  logic        tbl_we;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic [13:0] output_value;
  logic        data_good;
  logic        busy;
  logic        done;

  typedef struct {int value; int cyc;} exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;

  delay_sum_beamformer dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_index(sample_index),
    .sample_valid(sample_valid), .start(start), .num_points(num_points),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .tbl_we(tbl_we),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .output_value(output_value),
    .data_good(data_good), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding frame, in value and arrival cycle.
  always @(negedge clk) begin
    if (reset_n && data_good) begin
      strobe_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_strobe got value=%0d expected no strobe", output_value);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_output("frame_value", int'(output_value), e.value);
        check_output("frame_latency", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input int idx, input int s0, input int s1,
                                input int s2, input int s3);
    sample_valid = v;
    sample_index = 16'(idx);
    sample_in    = {12'(s3), 12'(s2), 12'(s1), 12'(s0)};
    step();
  endtask

  task automatic expect_frame(input int value);
    exp_t e;
    e.value = value;
    e.cyc   = cyc + 2;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int ch, input int d);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_delay = 5'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic tbl_write(input int addr, input int data);
    tbl_we = 1'b1; tbl_addr = 10'(addr); tbl_data = 16'(data);
    step();
    tbl_we = 1'b0;
  endtask

  task automatic start_scan(input int np);
    start = 1'b1; num_points = 11'(np);
    step();
    start = 1'b0;
  endtask

  task automatic wait_drain();
    sample_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    check_output("drain_pending", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #100us;
    $display("[TB] FAIL watchdog expired at cycle %0d expected completion", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0; sample_in = '0; sample_index = '0; sample_valid = 1'b0;
    start = 1'b0; num_points = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    step(); step();
    check_output("rst_output_value", int'(output_value), 0);
    check_output("rst_data_good", int'(data_good), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    reset_n = 1'b1;
    step();

    $display("[TB] zero delay single point");
    for (int k = 0; k < 4; k++) cfg_write(k, 0);
    tbl_write(0, 5);
    start_scan(1);
    check_output("t2_busy", int'(busy), 1);
    check_output("t2_done_in_run", int'(done), 0);
    apply_stimulus(1'b1, 3, 9, 9, 9, 9);
    expect_frame(1000);
    apply_stimulus(1'b1, 5, 100, 200, 300, 400);
    idle(3);
    check_output("t2_done", int'(done), 1);
    check_output("t2_busy_after", int'(busy), 0);
    wait_drain();

    $display("[TB] staggered delays on ramps");
    for (int k = 0; k < 4; k++) cfg_write(k, k);
    tbl_write(0, 10);
    tbl_write(1, 11);
    start_scan(2);
    for (int i = 0; i <= 11; i++) begin
      if (i == 10) expect_frame(80);
      if (i == 11) expect_frame(90);
      apply_stimulus(1'b1, i, i, 2*i, 3*i, 4*i);
    end
    idle(3);
    check_output("t3_done", int'(done), 1);
    wait_drain();

    $display("[TB] full scale and deepest delay");
    for (int k = 0; k < 4; k++) cfg_write(k, 0);
    tbl_write(0, 100);
    start_scan(1);
    expect_frame(16380);
    apply_stimulus(1'b1, 100, 4095, 4095, 4095, 4095);
    wait_drain();
    cfg_write(3, 31);
    tbl_write(0, 231);
    start_scan(1);
    for (int j = 0; j < 32; j++) begin
      if (j == 31) expect_frame(1000);
      apply_stimulus(1'b1, 200 + j, 0, 0, 0, 1000 + j);
    end
    wait_drain();
    check_output("t4_done", int'(done), 1);

    $display("[TB] valid gating and back-to-back matches");
    cfg_write(3, 0);
    tbl_write(0, 3);
    tbl_write(1, 4);
    tbl_write(2, 9);
    start_scan(3);
    strobe_cnt = 0;
    for (int i = 0; i <= 20; i++) begin
      if (i == 9) apply_stimulus(1'b0, 9, 999, 999, 999, 999);
      if (i == 3 || i == 4 || i == 9) expect_frame(4*i + 6);
      if (i == 6) continue;
      apply_stimulus((i == 1 || i == 5) ? 1'b0 : 1'b1, i, i, i+1, i+2, i+3);
    end
    wait_drain();
    check_output("t5_strobe_count", strobe_cnt, 3);
    check_output("t5_done", int'(done), 1);

    $display("[TB] config guard during run");
    tbl_write(0, 50);
    start_scan(1);
    cfg_write(0, 5);
    tbl_write(0, 60);
    for (int i = 45; i < 50; i++) apply_stimulus(1'b1, i, 7, 7, 7, 7);
    expect_frame(10);
    apply_stimulus(1'b1, 50, 1, 2, 3, 4);
    wait_drain();
    strobe_cnt = 0;
    start_scan(0);
    check_output("t6_np0_done", int'(done), 1);
    check_output("t6_np0_busy", int'(busy), 0);
    idle(4);
    check_output("t6_np0_strobes", strobe_cnt, 0);
    start_scan(1);
    check_output("t6_rerun_busy", int'(busy), 1);
    expect_frame(20);
    apply_stimulus(1'b1, 50, 5, 5, 5, 5);
    wait_drain();

    $display("[TB] reset with frame in flight");
    tbl_write(0, 70);
    tbl_write(1, 71);
    start_scan(2);
    apply_stimulus(1'b1, 70, 1, 1, 1, 1);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check_output("t1_rst_value", int'(output_value), 0);
    check_output("t1_rst_good", int'(data_good), 0);
    check_output("t1_rst_busy", int'(busy), 0);
    step();
    step();
    strobe_cnt = 0;
    reset_n = 1'b1;
    idle(6);
    check_output("t1_post_strobes", strobe_cnt, 0);
    check_output("t1_post_busy", int'(busy), 0);
    check_output("t1_post_done", int'(done), 0);
    check_output("t1_post_value", int'(output_value), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
